// File: rtl/piano_key_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : piano_key_if
//  Description : Raw button inputs and conditioned note/octave outputs of the
//                piano keyboard front end.
//  Revision    : 1.0  initial release
// ============================================================================
interface piano_key_if;
    logic btn_c, btn_d, btn_e, btn_f, btn_g, btn_a, btn_b;
    logic btn_up, btn_down;
    logic c, d, e, f, g, a, b;
    logic up, down;

    modport master (
        output btn_c, btn_d, btn_e, btn_f, btn_g, btn_a, btn_b, btn_up, btn_down,
        input  c, d, e, f, g, a, b, up, down
    );

    modport slave (
        input  btn_c, btn_d, btn_e, btn_f, btn_g, btn_a, btn_b, btn_up, btn_down,
        output c, d, e, f, g, a, b, up, down
    );
endinterface
`default_nettype wire

// File: rtl/piano_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : piano_key_conditioner
//  Description : Synchronises and debounces 7 note + 2 octave buttons, drives a
//                single priority-selected note and a LOW/MID/HIGH octave state.
//                Define OCTAVE_WRAP_EN to make the octave state wrap around.
//  Revision    : 1.0  initial release
// ============================================================================
module piano_key_conditioner #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    piano_key_if.slave  kbd
);
    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEB_CYCLES - 1);
    localparam logic [1:0]       c_LOW      = 2'b00;
    localparam logic [1:0]       c_MID      = 2'b01;
    localparam logic [1:0]       c_HIGH     = 2'b10;

    // Bit order: c,d,e,f,g,a,b occupy [6:0] (c highest priority), up=[7], down=[8]
    logic [8:0] w_raw;
    logic [8:0] r_meta;
    logic [8:0] r_sync;
    logic [8:0] w_deb;

    assign w_raw = {kbd.btn_down, kbd.btn_up, kbd.btn_b, kbd.btn_a, kbd.btn_g,
                    kbd.btn_f, kbd.btn_e, kbd.btn_d, kbd.btn_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    generate
        for (genvar i = 0; i < 9; i++) begin : g_deb
            logic [CNT_W-1:0] r_cnt;
            logic             r_lvl;

            // Counter only runs while the synced sample disagrees with the accepted level.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b0;
                end else if (r_sync[i] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_last) begin
                    r_lvl <= r_sync[i];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_deb[i] = r_lvl;
        end
    endgenerate

    // Isolating the lowest set bit gives the highest-priority pressed note.
    logic [6:0] w_note;
    logic [6:0] r_note;

    assign w_note = w_deb[6:0] & (~w_deb[6:0] + 7'd1);

    always_ff @(posedge clk) begin
        if (rst) r_note <= '0;
        else     r_note <= w_note;
    end

    logic [1:0] r_oct;
    logic [1:0] w_oct_nxt;
    logic       r_up_q;
    logic       r_down_q;
    logic       w_up_rise;
    logic       w_down_rise;

    assign w_up_rise   = w_deb[7] & ~r_up_q;
    assign w_down_rise = w_deb[8] & ~r_down_q;

    always_comb begin
        w_oct_nxt = r_oct;
        if (w_up_rise && !w_down_rise) begin
            case (r_oct)
                c_LOW:   w_oct_nxt = c_MID;
                c_MID:   w_oct_nxt = c_HIGH;
`ifdef OCTAVE_WRAP_EN
                c_HIGH:  w_oct_nxt = c_LOW;
`else
                c_HIGH:  w_oct_nxt = c_HIGH;
`endif
                default: w_oct_nxt = c_MID;
            endcase
        end else if (w_down_rise && !w_up_rise) begin
            case (r_oct)
                c_HIGH:  w_oct_nxt = c_MID;
                c_MID:   w_oct_nxt = c_LOW;
`ifdef OCTAVE_WRAP_EN
                c_LOW:   w_oct_nxt = c_HIGH;
`else
                c_LOW:   w_oct_nxt = c_LOW;
`endif
                default: w_oct_nxt = c_MID;
            endcase
        end else if (r_oct == 2'b11) begin
            w_oct_nxt = c_MID;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_oct    <= c_MID;
            r_up_q   <= 1'b0;
            r_down_q <= 1'b0;
        end else begin
            r_oct    <= w_oct_nxt;
            r_up_q   <= w_deb[7];
            r_down_q <= w_deb[8];
        end
    end

    assign kbd.c    = r_note[0];
    assign kbd.d    = r_note[1];
    assign kbd.e    = r_note[2];
    assign kbd.f    = r_note[3];
    assign kbd.g    = r_note[4];
    assign kbd.a    = r_note[5];
    assign kbd.b    = r_note[6];
    assign kbd.up   = (r_oct == c_HIGH);
    assign kbd.down = (r_oct == c_LOW);
endmodule
`default_nettype wire

// File: tb/tb_piano_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piano_key_conditioner
//  Description : Scoreboard bench for piano_key_conditioner with DEB_CYCLES=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_piano_key_conditioner;
    localparam int DEB = 4;
    localparam bit [8:0] K_C = 9'h001, K_D = 9'h002, K_E = 9'h004, K_G = 9'h010,
                         K_A = 9'h020, K_UP = 9'h080, K_DN = 9'h100;
    // Expected output word: {down, up, b, a, g, f, e, d, c}
    localparam bit [8:0] O_UP = 9'h080, O_DN = 9'h100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] raw = '0;

    piano_key_if kif ();

    assign kif.btn_c    = raw[0];
    assign kif.btn_d    = raw[1];
    assign kif.btn_e    = raw[2];
    assign kif.btn_f    = raw[3];
    assign kif.btn_g    = raw[4];
    assign kif.btn_a    = raw[5];
    assign kif.btn_b    = raw[6];
    assign kif.btn_up   = raw[7];
    assign kif.btn_down = raw[8];

    piano_key_conditioner #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .kbd (kif.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit [8:0] sb_q[$];

    // Reference model: 2-sample delay line, run-length debounce, priority pick, octave 0..2
    bit [8:0] m_s1, m_s2, m_lvl;
    int       m_run [9];
    bit       m_upq, m_dnq;
    int       m_oct = 1;
    bit [6:0] m_note;

    task automatic model_step(input bit r, input bit [8:0] x);
        bit [8:0] pre;
        bit       ru, rd;
        pre = m_lvl;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_upq = 0; m_dnq = 0;
            m_oct = 1; m_note = '0;
            for (int i = 0; i < 9; i++) m_run[i] = 0;
        end else begin
            m_note = '0;
            for (int i = 0; i < 7; i++) begin
                if (pre[i]) begin
                    m_note[i] = 1'b1;
                    break;
                end
            end
            ru = pre[7] && !m_upq;
            rd = pre[8] && !m_dnq;
            if (ru && !rd) begin
`ifdef OCTAVE_WRAP_EN
                m_oct = (m_oct + 1) % 3;
`else
                m_oct = (m_oct < 2) ? m_oct + 1 : 2;
`endif
            end else if (rd && !ru) begin
`ifdef OCTAVE_WRAP_EN
                m_oct = (m_oct + 2) % 3;
`else
                m_oct = (m_oct > 0) ? m_oct - 1 : 0;
`endif
            end
            m_upq = pre[7];
            m_dnq = pre[8];
            for (int i = 0; i < 9; i++) begin
                if (m_s2[i] != pre[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_lvl[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = x;
        end
        sb_q.push_back({m_oct == 0, m_oct == 2, m_note});
    endtask

    function automatic bit [8:0] dut_out();
        return {kif.down, kif.up, kif.b, kif.a, kif.g, kif.f, kif.e, kif.d, kif.c};
    endfunction

    // Monitor: the DUT presents a new output word every cycle.
    initial begin
        bit [8:0] expv, got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                expv = sb_q.pop_front();
                got  = dut_out();
                checks++;
                if (got !== expv) begin
                    failures++;
                    if (failures <= 30)
                        $display("FAIL scoreboard cycle %0d: got %b expected %b", cyc, got, expv);
                end
            end
        end
    end

    task automatic hold(input bit [8:0] pat, input int n);
        for (int k = 0; k < n; k++) begin
            raw = pat;
            @(posedge clk);
            model_step(rst, pat);
            cyc++;
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        hold(raw, n);
        rst = 1'b0;
    endtask

    task automatic check_dir(input string name, input bit [8:0] expv);
        bit [8:0] got;
        got = dut_out();
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, expv);
        end
    endtask

    task automatic press(input bit [8:0] k);
        hold(k, 12);
        hold('0, 12);
    endtask

    initial begin
        int rate;
        bit [8:0] pat;

        // Reset and idle
        do_reset(2);
        check_dir("reset_state", 9'h000);
        hold('0, 100);
        check_dir("idle_100", 9'h000);

        // Debounce: short glitch, then exact press/release latency
        hold(K_E, 3);
        hold('0, 12);
        check_dir("glitch_e", 9'h000);
        hold(K_E, 6);
        check_dir("e_press_6cyc", 9'h000);
        hold(K_E, 1);
        check_dir("e_press_7cyc", K_E);
        hold(K_E, 13);
        hold('0, 6);
        check_dir("e_release_6cyc", K_E);
        hold('0, 1);
        check_dir("e_release_7cyc", 9'h000);

        // Priority switch
        hold(K_G, 10);
        check_dir("g_alone", K_G);
        hold(K_G | K_D, 7);
        check_dir("d_over_g", K_D);
        hold(K_G, 7);
        check_dir("g_returns", K_G);
        hold('0, 10);

        // Octave stepping and saturation
        do_reset(2);
        press(K_UP);
        press(K_UP);
        press(K_UP);
        check_dir("oct_high_sat", O_UP);
        press(K_DN);
        check_dir("oct_mid", 9'h000);
        press(K_DN);
        press(K_DN);
        check_dir("oct_low_sat", O_DN);

        // Simultaneous up/down from MID
        do_reset(1);
        press(K_UP | K_DN);
        check_dir("simul_mid", 9'h000);
        press(K_UP);
        press(K_UP);
`ifdef OCTAVE_WRAP_EN
        check_dir("wrap_to_low", O_DN);
`else
        check_dir("high_stays", O_UP);
`endif

        // Reset mid-hold
        do_reset(1);
        press(K_UP);
        hold(K_A, 20);
        check_dir("a_held_high", K_A | O_UP);
        do_reset(1);
        check_dir("mid_reset", 9'h000);
        hold(K_A, 6);
        check_dir("a_after_rst_6", 9'h000);
        hold(K_A, 1);
        check_dir("a_after_rst_7", K_A);
        hold('0, 12);

        // Randomised segments with varying glitch density
        for (int s = 0; s < 40; s++) begin
            rate = $urandom_range(2, 30);
            for (int k = 0; k < 60; k++) begin
                pat = raw;
                if ($urandom_range(0, rate - 1) == 0)
                    pat[$urandom_range(0, 8)] ^= 1'b1;
                if ($urandom_range(0, 299) == 0) rst = 1'b1;
                hold(pat, 1);
                rst = 1'b0;
            end
        end

        hold('0, 3);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
